// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding,
// default bus timeout, and the store-side lane helpers.
// Package only: no ports.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Legal encoding for the direction and naturally aligned for its size.
  function automatic logic access_ok(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:         ok = 1'b1;
      F3_H:         ok = (off[0] == 1'b0);
      F3_W:         ok = (off == 2'b00);
      F3_BU, F3_HU: ok = !we && ((funct3 == F3_BU) || (off[0] == 1'b0));
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3,
                                            input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (funct3)
      F3_B:    s = 4'b0001 << off;
      F3_H:    s = 4'b0011 << off;
      F3_W:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate the store operand across lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                             input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (funct3)
      F3_B:    d = {4{wdata[7:0]}};
      F3_H:    d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load extraction: picks the addressed byte/halfword from the read word and
// sign- or zero-extends it to 32 bits. Purely combinational, no backpressure.
// Ports: rdata (bus word), off (addr[1:0]), funct3 (size/sign) -> result.
module load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = 16'h0000;
    result   = 32'h0000_0000;

    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_W:    result = rdata;
      F3_BU:   result = {24'h000000, byte_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit bridging one core access at a time onto a word-wide memory bus.
// Latency: accept at T, bus_req from T+1, resp_valid one cycle after bus_ack
// (minimum T+2); bad accesses respond at T+1. req_ready is low from accept to
// response; bus_req is held stable until bus_ack or TIMEOUT stalled cycles.
// Ports: req_* core request, resp_valid/resp_err/rdo completion,
//        bus_* memory side with same-cycle ack/rdata.
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] rdo,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           we_q;
  logic [2:0]     f3_q;
  logic [1:0]     off_q;
  logic [31:0]    ld_res;

  // Extraction runs on the live bus word; the result is only registered on ack.
  load_ext u_load_ext (
    .rdata  (bus_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdo        <= 32'h0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wstrb  <= 4'h0;
      bus_wdata  <= 32'h0;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            we_q      <= req_we;
            f3_q      <= req_funct3;
            off_q     <= req_addr[1:0];
            if (access_ok(req_we, req_funct3, req_addr[1:0])) begin
              state     <= ST_REQ;
              cnt       <= '0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wstrb <= req_we ? store_strb(req_funct3, req_addr[1:0]) : 4'b0000;
              bus_wdata <= req_we ? store_data(req_funct3, req_wdata) : 32'h0;
            end else begin
              // Rejected without touching the bus.
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdo        <= 32'h0;
            end
          end
        end
        ST_REQ: begin
          // Ack is tested first so a same-cycle ack beats the timeout.
          if (bus_ack) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            rdo        <= we_q ? 32'h0 : ld_res;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state      <= ST_RESP;
            bus_req    <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            rdo        <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          bus_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem with a transaction-level model of the expected
// per-cycle outputs, checked on every falling edge, plus literal pins.
module tb_lsu_mem;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] rdo;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  lsu_mem #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .rdo(rdo),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle, maintained by the stimulus.
  logic        chk_en = 1'b0;
  logic        e_ready, e_breq, e_rvalid, e_err, e_we;
  logic [31:0] e_rdo, e_addr, e_wdata;
  logic [3:0]  e_wstrb;

  // Values observed during the last access, for literal pinning.
  logic [31:0] seen_rdo, seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;
  logic        seen_err;
  int          seen_breq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("bus_req", 32'(bus_req), 32'(e_breq));
      chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
      chk("resp_err", 32'(resp_err), 32'(e_err));
      chk("rdo", rdo, e_rdo);
      if (e_breq) begin
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(e_wstrb));
        if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
      end
    end
  end

  // ---- Model: access rules expressed as sizes and arithmetic ----
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    if (f3 == 3'b010) return 4;
    return 0;
  endfunction

  function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    if (sz == 0) return 1'b0;
    if (we && f3[2]) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int sz;
    sz = size_of(f3);
    v  = rd >> (8 * a[1:0]);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    return 4'(((1 << sz) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = size_of(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic set_idle();
    e_ready  = 1'b1;
    e_breq   = 1'b0;
    e_rvalid = 1'b0;
  endtask

  // Runs one access starting just after a rising edge. waits<0 means never ack.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic ok, timed_out;
    int   n;
    ok        = m_legal(we, f3, a);
    timed_out = ok && !(waits >= 0 && waits < TO);
    n         = !ok ? 0 : (timed_out ? TO : waits + 1);

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    set_idle();
    @(posedge clk); #1;
    // Scramble request fields: the DUT must have registered them.
    req_valid  = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h5555_5555;
    req_funct3 = 3'b111;
    req_we     = ~we;
    e_ready    = 1'b0;
    e_addr     = a & 32'hFFFF_FFFC;
    e_we       = we;
    e_wstrb    = we ? m_strb(f3, a) : 4'b0000;
    e_wdata    = m_wdata(f3, wd);
    seen_breq  = 0;
    for (int k = 0; k < n; k++) begin
      e_breq    = 1'b1;
      bus_ack   = (k == waits);
      bus_rdata = (k == waits) ? rd : ~rd;
      if (k == 0) begin
        seen_addr  = bus_addr;
        seen_wstrb = bus_wstrb;
        seen_wdata = bus_wdata;
      end
      if (bus_req) seen_breq++;
      @(posedge clk); #1;
    end
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    e_breq    = 1'b0;
    e_rvalid  = 1'b1;
    e_err     = !ok || timed_out;
    e_rdo     = (e_err || we) ? 32'h0 : m_load(f3, a, rd);
    seen_rdo  = rdo;
    seen_err  = resp_err;
    if (bus_req) seen_breq++;
    @(posedge clk); #1;
    set_idle();
  endtask

  task automatic idle_cycles(input int n, input logic ack);
    set_idle();
    for (int i = 0; i < n; i++) begin
      bus_ack   = ack;
      bus_rdata = 32'hA5A5_A5A5;
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    e_rdo = 32'h0; e_err = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
    e_wstrb = 4'h0; e_we = 1'b0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(1, 1'b0);

    // LB 0x103, ack with no waits
    do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 0);
    chk("lb_rdo_lit", seen_rdo, 32'hFFFF_FF80);
    chk("lb_err_lit", 32'(seen_err), 32'h0);

    // SH 0x202
    do_access(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 0);
    chk("sh_addr_lit", seen_addr, 32'h0000_0200);
    chk("sh_wstrb_lit", 32'(seen_wstrb), 32'hC);
    chk("sh_wdata_lit", seen_wdata, 32'hABCD_ABCD);
    chk("sh_rdo_lit", seen_rdo, 32'h0);

    // LW misaligned
    do_access(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0);
    chk("lw_mis_err_lit", 32'(seen_err), 32'h1);
    chk("lw_mis_breq_lit", 32'(seen_breq), 32'h0);

    // Stray acks while idle must be ignored
    idle_cycles(2, 1'b1);

    // Timeout: never ack
    do_access(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_2222, -1);
    chk("to_breq_cycles_lit", 32'(seen_breq), 32'd4);
    chk("to_err_lit", 32'(seen_err), 32'h1);

    // Ack on the last allowed cycle wins over the timeout
    do_access(1'b1, 3'b010, 32'h0000_0044, 32'h1234_5678, 32'h0, 3);
    chk("to_ack_err_lit", 32'(seen_err), 32'h0);

    // LHU after 3 waits
    do_access(1'b0, 3'b101, 32'h0000_0012, 32'h0, 32'h9ABC_0000, 3);
    chk("lhu_rdo_lit", seen_rdo, 32'h0000_9ABC);

    // Remaining extraction / store lanes
    do_access(1'b0, 3'b001, 32'h0000_0010, 32'h0, 32'h0000_8001, 1);
    do_access(1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_C300, 2);
    do_access(1'b1, 3'b000, 32'h0000_0301, 32'hFFFF_FF5A, 32'h0, 0);
    chk("sb_wstrb_lit", 32'(seen_wstrb), 32'h2);
    chk("sb_wdata_lit", seen_wdata, 32'h5A5A_5A5A);
    do_access(1'b0, 3'b010, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 2);
    do_access(1'b0, 3'b000, 32'h0000_0000, 32'h0, 32'h0000_007F, 0);

    // Illegal encodings and misaligned halfword store
    do_access(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0);
    do_access(1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 0);
    do_access(1'b1, 3'b001, 32'h0000_0203, 32'h0, 32'h0, 0);
    do_access(1'b0, 3'b111, 32'h0000_0000, 32'h0, 32'h0, 0);

    // Reset during an outstanding access
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_0080;
    set_idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    e_ready   = 1'b0;
    e_breq    = 1'b1;
    e_addr    = 32'h0000_0080;
    e_we      = 1'b0;
    e_wstrb   = 4'b0000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst    = 1'b0;
    e_rdo  = 32'h0;
    e_err  = 1'b0;
    set_idle();
    chk("rst_breq_lit", 32'(bus_req), 32'h0);
    chk("rst_ready_lit", 32'(req_ready), 32'h1);
    idle_cycles(2, 1'b0);

    // Normal operation after the abort
    do_access(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hFEDC_0000, 1);
    chk("post_rst_rdo_lit", seen_rdo, 32'h0000_FEDC);
    idle_cycles(2, 1'b0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
